// File: rtl/servo_cmd_decoder.sv
// Servo command decoder.
// Parses ASCII angle commands (1-3 digits terminated by CR or LF) from the
// UART receiver. Each accepted angle becomes a pulse-width target. The output
// is stepped toward that target once per update period, so the servo never
// jumps to a new position.
module servo_cmd_decoder #(
    parameter int c_Multiply_By = 753,
    parameter int c_Max_Angle   = 180,
    parameter int c_Reset_Angle = 90,
    parameter int c_Step        = 7530,
    parameter int c_Update_Clks = 303_030
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic [23:0] o_Control_Range,
    output logic        o_Cmd_Valid,
    output logic        o_Cmd_Err,
    output logic        o_Busy
);

    localparam int TICK_W = (c_Update_Clks > 1) ? $clog2(c_Update_Clks) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(c_Update_Clks - 1);
    localparam logic [23:0]       RESET_RANGE = 24'(c_Reset_Angle * c_Multiply_By);
    localparam logic [23:0]       MULT        = 24'(c_Multiply_By);
    localparam logic [23:0]       STEP        = 24'(c_Step);
    localparam logic [7:0]        MAX_ANGLE   = 8'(c_Max_Angle);

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        ERROR,
        COMMIT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [7:0]        acc;
    logic [7:0]        next_acc;
    logic [1:0]        digit_cnt;
    logic [1:0]        next_cnt;
    logic              load_target;
    logic              valid_next;
    logic              err_next;
    logic              is_digit;
    logic              is_term;
    logic [3:0]        digit_val;
    logic [11:0]       mac;
    logic [7:0]        mac_sat;
    logic [23:0]       target;
    logic [23:0]       up_gap;
    logic [23:0]       dn_gap;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign is_digit  = (i_RX_Byte >= 8'h30) && (i_RX_Byte <= 8'h39);
    assign is_term   = (i_RX_Byte == 8'h0D) || (i_RX_Byte == 8'h0A);
    assign digit_val = i_RX_Byte[3:0];

    // A three-digit value can exceed 8 bits. Saturating it at 255 keeps it
    // above the legal maximum, so such commands are rejected rather than
    // wrapping to a small, legal-looking angle.
    assign mac     = ({4'd0, acc} * 12'd10) + {8'd0, digit_val};
    assign mac_sat = (mac > 12'd255) ? 8'hFF : mac[7:0];

    assign up_gap = target - o_Control_Range;
    assign dn_gap = o_Control_Range - target;
    assign tick   = (tick_cnt == TICK_LAST);

    // Parser next-state logic. COMMIT lasts one cycle, and a byte arriving
    // during COMMIT is treated exactly as if the parser were already idle.
    always_comb begin
        next_state  = state;
        next_acc    = acc;
        next_cnt    = digit_cnt;
        load_target = 1'b0;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE, COMMIT: begin
                if (state == COMMIT) begin
                    load_target = 1'b1;
                    valid_next  = 1'b1;
                end
                next_state = IDLE;
                if (i_RX_DV) begin
                    if (is_digit) begin
                        next_acc   = {4'd0, digit_val};
                        next_cnt   = 2'd1;
                        next_state = DIGITS;
                    end else if (!is_term) begin
                        next_state = ERROR;
                    end
                end
            end
            DIGITS: begin
                if (i_RX_DV) begin
                    if (is_digit) begin
                        if (digit_cnt == 2'd3) begin
                            next_state = ERROR;
                        end else begin
                            next_acc = mac_sat;
                            next_cnt = digit_cnt + 2'd1;
                        end
                    end else if (is_term) begin
                        if (acc <= MAX_ANGLE) begin
                            next_state = COMMIT;
                        end else begin
                            err_next   = 1'b1;
                            next_state = IDLE;
                        end
                    end else begin
                        next_state = ERROR;
                    end
                end
            end
            ERROR: begin
                if (i_RX_DV && is_term) begin
                    err_next   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Parser state, accumulator and registered status pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            acc         <= 8'd0;
            digit_cnt   <= 2'd0;
            o_Cmd_Valid <= 1'b0;
            o_Cmd_Err   <= 1'b0;
        end else begin
            state       <= next_state;
            acc         <= next_acc;
            digit_cnt   <= next_cnt;
            o_Cmd_Valid <= valid_next;
            o_Cmd_Err   <= err_next;
        end
    end

    // Latch the new pulse-width target when a command commits.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            target <= RESET_RANGE;
        end else if (load_target) begin
            target <= {16'd0, acc} * MULT;
        end
    end

    // Free-running update-period counter. It is never re-phased by commands.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // On each tick, step the output toward the target. If the output is
    // within one step of the target, it lands on it exactly.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Control_Range <= RESET_RANGE;
        end else if (tick) begin
            if (target >= o_Control_Range) begin
                if (up_gap <= STEP) begin
                    o_Control_Range <= target;
                end else begin
                    o_Control_Range <= o_Control_Range + STEP;
                end
            end else begin
                if (dn_gap <= STEP) begin
                    o_Control_Range <= target;
                end else begin
                    o_Control_Range <= o_Control_Range - STEP;
                end
            end
        end
    end

    // Busy flag: registered, so it trails changes of output or target by one clock.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Busy <= 1'b0;
        end else begin
            o_Busy <= (o_Control_Range != target);
        end
    end

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// Testbench for servo_cmd_decoder.
// Uses a short update period (4 clocks) and a step of 1000 so that ramps
// complete quickly.
module tb_servo_cmd_decoder;

    logic        i_Clk     = 1'b0;
    logic        i_Rst_L   = 1'b0;
    logic        i_RX_DV   = 1'b0;
    logic [7:0]  i_RX_Byte = 8'h00;
    logic [23:0] o_Control_Range;
    logic        o_Cmd_Valid;
    logic        o_Cmd_Err;
    logic        o_Busy;

    int checks         = 0;
    int errors         = 0;
    int neg_count      = 0;
    int last_dv_neg    = 0;
    int last_valid_neg = 0;
    int valid_total    = 0;
    int err_total      = 0;

    typedef struct {
        string name;
        string cmd;
        int    n_valid;
        int    n_err;
        int    range;
    } vec_t;

    vec_t vecs[9];

    servo_cmd_decoder #(
        .c_Multiply_By(753),
        .c_Max_Angle  (180),
        .c_Reset_Angle(90),
        .c_Step       (1000),
        .c_Update_Clks(4)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_RX_DV        (i_RX_DV),
        .i_RX_Byte      (i_RX_Byte),
        .o_Control_Range(o_Control_Range),
        .o_Cmd_Valid    (o_Cmd_Valid),
        .o_Cmd_Err      (o_Cmd_Err),
        .o_Busy         (o_Busy)
    );

    // Free-running clock.
    always #5 i_Clk = ~i_Clk;

    // Pulse monitor: counts pulses and records the cycle of the most recent strobe and valid pulse.
    always @(negedge i_Clk) begin
        neg_count = neg_count + 1;
        if (i_RX_DV) last_dv_neg = neg_count;
        if (o_Cmd_Valid) begin
            valid_total    = valid_total + 1;
            last_valid_neg = neg_count;
        end
        if (o_Cmd_Err) err_total = err_total + 1;
    end

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got time limit reached, expected completion");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic align();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            i_RX_DV   = 1'b1;
            i_RX_Byte = s[i];
            @(posedge i_Clk);
            #1;
        end
        i_RX_DV = 1'b0;
    endtask

    task automatic waitValid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_Clk);
            seen = o_Cmd_Valid;
        end
        checkOutput({name, " valid seen"}, seen, 1);
    endtask

    task automatic watchRamp(input int target, input string name, output int last_delta);
        int prev;
        int cur;
        int gap;
        int want;
        int since;
        bit landed;
        bit first;
        last_delta = 0;
        first      = 1'b1;
        since      = 0;
        @(negedge i_Clk);
        prev   = int'(o_Control_Range);
        landed = (prev == target);
        for (int i = 0; i < 1500 && !landed; i++) begin
            @(negedge i_Clk);
            since = since + 1;
            cur   = int'(o_Control_Range);
            if (cur != prev) begin
                gap = target - prev;
                if (gap > 1000)       want = 1000;
                else if (gap < -1000) want = -1000;
                else                  want = gap;
                checkOutput({name, " step"}, cur - prev, want);
                if (first) checkOutput({name, " busy during ramp"}, o_Busy, 1);
                else       checkOutput({name, " tick spacing"}, since, 4);
                first      = 1'b0;
                since      = 0;
                last_delta = cur - prev;
                prev       = cur;
                landed     = (cur == target);
            end
        end
        checkOutput({name, " final"}, prev, target);
        @(negedge i_Clk);
        checkOutput({name, " busy clear"}, o_Busy, 0);
    endtask

    // Directed test sequence.
    initial begin
        int v0;
        int e0;
        int ld;
        bit done;

        vecs[0] = '{"t4 181",      "181\015",        0, 1, 0};
        vecs[1] = '{"t4 1234",     "1234\015",       0, 1, 0};
        vecs[2] = '{"t4 9x",       "9x\015",         0, 1, 0};
        vecs[3] = '{"300 sat",     "300\015",        0, 1, 0};
        vecs[4] = '{"blank lines", "\015\012\012",   0, 0, 0};
        vecs[5] = '{"leading 0s",  "007\012",        1, 0, 5271};
        vecs[6] = '{"b2b cmds",    "12\0153\015",    2, 0, 2259};
        vecs[7] = '{"err then ok", "x\0125\012",     1, 1, 3765};
        vecs[8] = '{"err discard", "A12\015\012",    0, 1, 3765};

        #12;
        checkOutput("t1 reset range", o_Control_Range, 67770);
        checkOutput("t1 reset busy", o_Busy, 0);
        checkOutput("t1 reset valid", o_Cmd_Valid, 0);
        checkOutput("t1 reset err", o_Cmd_Err, 0);
        align();
        i_Rst_L = 1'b1;
        idle(50);
        checkOutput("t1 idle range", o_Control_Range, 67770);
        checkOutput("t1 idle busy", o_Busy, 0);
        checkOutput("t1 idle valid pulses", valid_total, 0);
        checkOutput("t1 idle err pulses", err_total, 0);

        $display("[TB] test 2: ramp up to 180 degrees");
        v0 = valid_total;
        applyStimulus("180\015");
        watchRamp(135540, "t2", ld);
        align();
        checkOutput("t2 last step", ld, 770);
        checkOutput("t2 valid latency", last_valid_neg - last_dv_neg, 2);
        checkOutput("t2 valid count", valid_total - v0, 1);

        $display("[TB] test 3: ramp down to 0");
        v0 = valid_total;
        e0 = err_total;
        applyStimulus("0\012\015");
        watchRamp(0, "t3", ld);
        align();
        checkOutput("t3 last step", ld, -540);
        checkOutput("t3 valid count", valid_total - v0, 1);
        checkOutput("t3 err count", err_total - e0, 0);

        $display("[TB] table vectors");
        for (int k = 0; k < 9; k++) begin
            v0 = valid_total;
            e0 = err_total;
            applyStimulus(vecs[k].cmd);
            idle(20);
            checkOutput({vecs[k].name, " valid count"}, valid_total - v0, vecs[k].n_valid);
            checkOutput({vecs[k].name, " err count"}, err_total - e0, vecs[k].n_err);
            done = 1'b0;
            for (int i = 0; i < 1500 && !done; i++) begin
                @(negedge i_Clk);
                done = !o_Busy;
            end
            checkOutput({vecs[k].name, " settled"}, done, 1);
            align();
            checkOutput({vecs[k].name, " range"}, o_Control_Range, vecs[k].range);
        end

        $display("[TB] test 5: retarget mid-ramp");
        applyStimulus("180\015");
        waitValid("t5 first");
        align();
        idle(180);
        checkOutput("t5 above new target", (int'(o_Control_Range) > 33885), 1);
        applyStimulus("45\015");
        waitValid("t5 second");
        watchRamp(33885, "t5", ld);
        align();

        $display("[TB] test 6: reset mid-command and mid-ramp");
        applyStimulus("180\015");
        idle(40);
        applyStimulus("12");
        #2;
        i_Rst_L = 1'b0;
        #1;
        checkOutput("t6 reset range", o_Control_Range, 67770);
        checkOutput("t6 reset busy", o_Busy, 0);
        checkOutput("t6 reset valid", o_Cmd_Valid, 0);
        checkOutput("t6 reset err", o_Cmd_Err, 0);
        idle(3);
        i_Rst_L = 1'b1;
        align();
        v0 = valid_total;
        e0 = err_total;
        applyStimulus("3\015");
        watchRamp(2259, "t6", ld);
        align();
        checkOutput("t6 valid count", valid_total - v0, 1);
        checkOutput("t6 err count", err_total - e0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
